// File: rtl/pc_branch_unit_pkg.sv
// Shared KGP-miniRISC definitions: branch opcodes, PC sequencer states and the PC step.
package miniRISC_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_B    = 4'd1,
    BR_BR   = 4'd2,
    BR_BLTZ = 4'd3,
    BR_BZ   = 4'd4,
    BR_BNZ  = 4'd5,
    BR_BL   = 4'd6,
    BR_BCY  = 4'd7,
    BR_BNCY = 4'd8
  } br_op_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Bundle between the ALU/decoder side (master) and the PC/branch unit (slave).
interface pc_branch_unit_if
  import miniRISC_pkg::*;
#(
  parameter int PC_WIDTH = 32
);
  // instr_valid is a one-cycle strobe with no ready: every master output must be
  // valid during the cycle instr_valid is high, and is sampled at its closing edge.
  logic [PC_WIDTH-1:0] alu_result;
  logic                alu_carry;
  logic                alu_sign;
  logic                alu_zero;
  logic [3:0]          branch_op;
  logic [PC_WIDTH-1:0] branch_offset;
  logic                carry_we;
  logic                halt_req;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_valid;
  logic                link_we;
  logic [PC_WIDTH-1:0] link_value;
  logic                carry_flag;
  logic                halted;
  pc_state_t           state_dbg;

  modport master (
    output alu_result, alu_carry, alu_sign, alu_zero, branch_op, branch_offset,
           carry_we, halt_req,
    input  pc, instr_valid, link_we, link_value, carry_flag, halted, state_dbg
  );

  modport slave (
    input  alu_result, alu_carry, alu_sign, alu_zero, branch_op, branch_offset,
           carry_we, halt_req,
    output pc, instr_valid, link_we, link_value, carry_flag, halted, state_dbg
  );
endinterface

// File: rtl/pc_branch_unit_branch_resolve.sv
// Combinational next-PC selection for every branch kind; all adds wrap modulo 2^PC_WIDTH.
module branch_resolve
  import miniRISC_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [3:0]          branch_op,
  input  logic                alu_sign,
  input  logic                alu_zero,
  input  logic                carry_flag,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic [PC_WIDTH-1:0] alu_result,
  output logic [PC_WIDTH-1:0] next_pc
);
  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] tgt;

  assign seq = pc + PC_WIDTH'(PC_INCR);
  assign tgt = seq + branch_offset;

  always_comb begin
    next_pc = seq;
    case (branch_op)
      BR_NONE: next_pc = seq;
      BR_B:    next_pc = tgt;
      BR_BR:   next_pc = alu_result;
      BR_BLTZ: next_pc = alu_sign ? tgt : seq;
      BR_BZ:   next_pc = alu_zero ? tgt : seq;
      BR_BNZ:  next_pc = alu_zero ? seq : tgt;
      BR_BL:   next_pc = tgt;
      // carry branches see the registered flag, not this cycle's ALU carry
      BR_BCY:  next_pc = carry_flag ? tgt : seq;
      BR_BNCY: next_pc = carry_flag ? seq : tgt;
      default: next_pc = seq;
    endcase
  end
endmodule

// File: rtl/pc_branch_unit.sv
// PC sequencer: FETCH waits IMEM_LATENCY cycles, EXEC commits one instruction's
// branch and carry update, HALT holds everything until reset.
module pc_branch_unit
  import miniRISC_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  IMEM_LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  pc_branch_unit_if.slave bus
);
  pc_state_t           state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [PC_WIDTH-1:0] pc_q, pc_nxt;
  logic                carry_q, carry_nxt;
  logic [PC_WIDTH-1:0] resolved_pc;

  branch_resolve #(.PC_WIDTH(PC_WIDTH)) u_resolve (
    .branch_op     (bus.branch_op),
    .alu_sign      (bus.alu_sign),
    .alu_zero      (bus.alu_zero),
    .carry_flag    (carry_q),
    .pc            (pc_q),
    .branch_offset (bus.branch_offset),
    .alu_result    (bus.alu_result),
    .next_pc       (resolved_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cnt     <= '0;
      pc_q    <= RESET_PC;
      carry_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pc_q    <= pc_nxt;
      carry_q <= carry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc_q;
    carry_nxt = carry_q;
    case (state)
      FETCH: begin
        if (cnt == 4'(IMEM_LATENCY - 1)) begin
          state_nxt = EXEC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      EXEC: begin
        // halt wins outright: neither the branch nor the carry write lands
        if (bus.halt_req) begin
          state_nxt = HALT;
        end else begin
          state_nxt = FETCH;
          pc_nxt    = resolved_pc;
          if (bus.carry_we) carry_nxt = bus.alu_carry;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.carry_flag  = carry_q;
  assign bus.instr_valid = (state == EXEC);
  assign bus.halted      = (state == HALT);
  assign bus.link_we     = (state == EXEC) && (bus.branch_op == BR_BL) && !bus.halt_req;
  assign bus.link_value  = pc_q + PC_WIDTH'(PC_INCR);
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed checks of the PC/branch unit at IMEM_LATENCY=1, plus a latency-3 instance for pacing.
module tb_pc_branch_unit;
  import miniRISC_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_branch_unit_if #(.PC_WIDTH(32)) bus ();
  pc_branch_unit_if #(.PC_WIDTH(32)) bus3 ();

  pc_branch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_LATENCY(1)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  pc_branch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .IMEM_LATENCY(3)) dut3 (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_result = '0; bus.alu_carry = 1'b0; bus.alu_sign = 1'b0; bus.alu_zero = 1'b0;
    bus.branch_op = BR_NONE; bus.branch_offset = '0; bus.carry_we = 1'b0; bus.halt_req = 1'b0;
  endtask

  // Waits (bounded) for an EXEC cycle and drives this instruction's inputs into it.
  task automatic exec_drive(input logic [3:0] op, input logic [31:0] off, input logic [31:0] res,
                            input logic cy, input logic sg, input logic zr,
                            input logic cwe, input logic hlt);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.instr_valid && n < 20);
    if (!bus.instr_valid) check("exec_timeout", 32'(bus.instr_valid), 32'd1);
    bus.branch_op = op; bus.branch_offset = off; bus.alu_result = res;
    bus.alu_carry = cy; bus.alu_sign = sg; bus.alu_zero = zr;
    bus.carry_we = cwe; bus.halt_req = hlt;
    #1;
  endtask

  task automatic exec_commit();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic set_pc(input logic [31:0] v);
    exec_drive(BR_BR, 32'h0, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exec_commit();
  endtask

  task automatic branch(input string tag, input logic [3:0] op, input logic [31:0] off,
                        input logic sg, input logic zr, input logic [31:0] exp_pc);
    exec_drive(op, off, 32'h0, 1'b0, sg, zr, 1'b0, 1'b0);
    exec_commit();
    check(tag, bus.pc, exp_pc);
  endtask

  initial begin
    idle_inputs();
    bus3.alu_result = '0; bus3.alu_carry = 1'b0; bus3.alu_sign = 1'b0; bus3.alu_zero = 1'b0;
    bus3.branch_op = BR_NONE; bus3.branch_offset = '0; bus3.carry_we = 1'b0; bus3.halt_req = 1'b0;

    // 1. reset state and sequential pacing
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'(FETCH));
    check("rst_carry", 32'(bus.carry_flag), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_link_we", 32'(bus.link_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("lat1_valid_%0d", i), 32'(bus.instr_valid), 32'((i % 2) == 1));
      check($sformatf("lat1_pc_%0d", i), bus.pc, 32'(4 * (i / 2)));
      check($sformatf("lat3_valid_%0d", i), 32'(bus3.instr_valid), 32'((i % 4) == 3));
      check($sformatf("lat3_pc_%0d", i), bus3.pc, 32'(4 * (i / 4)));
    end

    // 2. flag-conditional branches from pc=0x10, offset 0x20
    set_pc(32'h10); branch("bz_taken",     BR_BZ,   32'h20, 1'b0, 1'b1, 32'h34);
    set_pc(32'h10); branch("bz_not",       BR_BZ,   32'h20, 1'b0, 1'b0, 32'h14);
    set_pc(32'h10); branch("bnz_taken",    BR_BNZ,  32'h20, 1'b0, 1'b0, 32'h34);
    set_pc(32'h10); branch("bnz_not",      BR_BNZ,  32'h20, 1'b0, 1'b1, 32'h14);
    set_pc(32'h10); branch("bltz_taken",   BR_BLTZ, 32'h20, 1'b1, 1'b0, 32'h34);
    set_pc(32'h10); branch("bltz_not",     BR_BLTZ, 32'h20, 1'b0, 1'b0, 32'h14);

    // 3. carry branch uses the flag from before this cycle's write
    set_pc(32'h40);
    exec_drive(BR_BCY, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exec_commit();
    check("bcy_old_flag_pc", bus.pc, 32'h44);
    check("bcy_carry_set", 32'(bus.carry_flag), 32'd1);
    branch("bcy_taken", BR_BCY, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h40);
    check("bcy_carry_held", 32'(bus.carry_flag), 32'd1);
    branch("bncy_not", BR_BNCY, 32'h100, 1'b0, 1'b0, 32'h44);

    // 4. branch-and-link and register return
    set_pc(32'h100);
    exec_drive(BR_BL, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bl_link_we", 32'(bus.link_we), 32'd1);
    check("bl_link_value", bus.link_value, 32'h104);
    exec_commit();
    check("bl_pc", bus.pc, 32'h144);
    check("bl_link_we_off", 32'(bus.link_we), 32'd0);
    exec_drive(BR_BR, 32'h0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_link_we", 32'(bus.link_we), 32'd0);
    exec_commit();
    check("br_pc", bus.pc, 32'h104);

    // 5. wraparound and reserved opcode
    set_pc(32'hFFFF_FFFC); branch("wrap_seq", BR_NONE, 32'h0, 1'b0, 1'b0, 32'h0);
    set_pc(32'h8);         branch("wrap_back", BR_B, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    branch("reserved_op", 4'd12, 32'h40, 1'b0, 1'b1, 32'h0);

    // 6. halt beats branch and carry write, then reset exits
    set_pc(32'h200);
    exec_drive(BR_B, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exec_commit();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("halt_pc_%0d", i), bus.pc, 32'h200);
      check($sformatf("halt_carry_%0d", i), 32'(bus.carry_flag), 32'd1);
      check($sformatf("halt_flag_%0d", i), 32'(bus.halted), 32'd1);
      check($sformatf("halt_valid_%0d", i), 32'(bus.instr_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("halt_rst_pc", bus.pc, 32'h0);
    check("halt_rst_state", 32'(bus.state_dbg), 32'(FETCH));
    check("halt_rst_halted", 32'(bus.halted), 32'd0);
    check("halt_rst_carry", 32'(bus.carry_flag), 32'd0);

    exec_drive(BR_NONE, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    exec_commit();
    check("pre_rst_pc", bus.pc, 32'h4);
    check("pre_rst_carry", 32'(bus.carry_flag), 32'd1);
    @(negedge clk);
    check("mid_fetch_state", 32'(bus3.state_dbg), 32'(FETCH));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("fetch_rst_pc", bus.pc, 32'h0);
    check("fetch_rst_carry", 32'(bus.carry_flag), 32'd0);
    check("fetch_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("fetch_rst_pc3", bus3.pc, 32'h0);
    check("fetch_rst_state3", 32'(bus3.state_dbg), 32'(FETCH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
